dmem_responder: RTL and testbench

- Data-memory target for the core's load/store path; it is the responder end of the `_mem_read_`/`_mem_write_` request the processor issues.
- Accepts one load or store at a time over a valid/ready request channel and performs RV64 byte/half/word/double access with sign or zero extension.
- Returns the result on a valid/ready response channel after a fixed, parameterised latency.
- Backed by an internal doubleword array; sits between the processor's ALU result/rs2 data and the write-back mux.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one RV64 load/store at a time over valid/ready, response after LATENCY cycles.
// Request accepted only in IDLE; the response is held until rsp_ready, then the next request can be taken.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            q_we;
  logic [63:0]     q_addr, q_wdata;
  logic [2:0]      q_f3;
  logic [63:0]     mem [DEPTH];

  logic            accept, access;
  logic [2:0]      lane;
  logic [1:0]      size;
  logic [IW-1:0]   idx;
  logic [5:0]      shamt;
  logic            oor, misal, illegal, err;
  logic [63:0]     dword, sh, ld_val, smask, wmask, wnew;

  assign accept = (state == IDLE) && req_valid;
  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_f3    <= '0;
    end else if (accept) begin
      cnt     <= CW'(LATENCY - 1);
      q_we    <= req_we;
      q_addr  <= req_addr;
      q_wdata <= req_wdata;
      q_f3    <= req_funct3;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign lane  = q_addr[2:0];
  assign size  = q_f3[1:0];
  assign idx   = q_addr[3 +: IW];
  assign shamt = {lane, 3'b000};

  always_comb begin
    oor     = |q_addr[63:3+IW];
    illegal = q_we ? q_f3[2] : (q_f3 == 3'b111);
    case (size)
      2'd1:    misal = lane[0];
      2'd2:    misal = |lane[1:0];
      2'd3:    misal = |lane;
      default: misal = 1'b0;
    endcase
    err = oor | misal | illegal;
  end

  // Loads shift the addressed lane down to bit 0; funct3[2] selects zero-extension.
  always_comb begin
    dword = mem[idx];
    sh    = dword >> shamt;
    case (size)
      2'd0:    ld_val = q_f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    ld_val = q_f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    ld_val = q_f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld_val = sh;
    endcase
    case (size)
      2'd0:    smask = 64'h0000_0000_0000_00FF;
      2'd1:    smask = 64'h0000_0000_0000_FFFF;
      2'd2:    smask = 64'h0000_0000_FFFF_FFFF;
      default: smask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    wmask = smask << shamt;
    wnew  = (dword & ~wmask) | ((q_wdata << shamt) & wmask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= err;
      rsp_rdata <= (err || q_we) ? 64'd0 : ld_val;
    end
  end

  // Array is never reset; a reset during BUSY forces IDLE so the store never commits.
  always_ff @(posedge clk) begin
    if (access && q_we && !err) mem[idx] <= wnew;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: byte-array reference model, directed plan then random traffic.
module tb_dmem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by directed code
  logic [7:0]  bmem [DEPTH*8];
  logic [64:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as plain bytes, result built from the RISC-V rules.
  function automatic logic [64:0] model(input bit we, input logic [63:0] addr,
                                        input logic [63:0] wdata, input logic [2:0] f3);
    int nb;
    bit bad;
    logic [63:0] v;
    nb  = 1 << f3[1:0];
    bad = (addr >= 64'(DEPTH*8)) || ((addr % 64'(nb)) != 0) || (we ? f3[2] : (f3 == 3'b111));
    if (bad) return {1'b1, 64'd0};
    if (we) begin
      for (int i = 0; i < nb; i++) bmem[int'(addr) + i] = wdata[8*i +: 8];
      return {1'b0, 64'd0};
    end
    v = 64'd0;
    for (int i = 0; i < nb; i++) v = v | (64'(bmem[int'(addr) + i]) << (8*i));
    if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    return {1'b0, v};
  endfunction

  task automatic do_req(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [2:0] f3, input bit push, input bit use_c,
                        input logic [63:0] c_rdata, input bit c_err);
    logic [64:0] e;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (push) begin
      e = model(we, addr, wdata, f3);
      if (use_c) e = {c_err, c_rdata};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
  endtask

  // rsp_ready driver
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0)      rsp_ready = 1'b1;
    else if (rdy_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency of each response and scoreboard compare at handshake
  initial begin
    logic prev;
    logic [64:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid && !prev) check("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
      prev = rsp_valid;
      if (reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_err", 64'(rsp_err), 64'(e[64]));
          check("rsp_rdata", rsp_rdata, e[63:0]);
        end
      end
    end
  end

  initial begin
    logic [63:0] rd0;
    logic        e0;
    logic [63:0] a;
    logic [2:0]  f;
    logic        w;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b1;

    // Fill the whole array so later random loads have defined contents.
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 64'(i*8), {$urandom, $urandom}, 3'b011, 1'b1, 1'b0, 64'd0, 1'b0);

    do_req(1'b1, 64'h10, 64'h8877665544332211, 3'b011, 1, 1, 64'd0, 0);
    do_req(1'b0, 64'h10, 64'd0, 3'b011, 1, 1, 64'h8877665544332211, 0);
    do_req(1'b0, 64'h17, 64'd0, 3'b000, 1, 1, 64'hFFFFFFFFFFFFFF88, 0);
    do_req(1'b0, 64'h17, 64'd0, 3'b100, 1, 1, 64'h0000000000000088, 0);
    do_req(1'b0, 64'h16, 64'd0, 3'b001, 1, 1, 64'hFFFFFFFFFFFF8877, 0);
    do_req(1'b0, 64'h14, 64'd0, 3'b010, 1, 1, 64'hFFFFFFFF88776655, 0);
    do_req(1'b0, 64'h14, 64'd0, 3'b110, 1, 1, 64'h0000000088776655, 0);
    do_req(1'b1, 64'h11, 64'hFFFFFFFFFFFFFFAB, 3'b000, 1, 1, 64'd0, 0);
    do_req(1'b0, 64'h10, 64'd0, 3'b011, 1, 1, 64'h887766554433AB11, 0);
    do_req(1'b1, 64'h12, 64'h000000000000BEEF, 3'b001, 1, 1, 64'd0, 0);
    do_req(1'b0, 64'h10, 64'd0, 3'b011, 1, 1, 64'h88776655BEEFAB11, 0);
    do_req(1'b0, 64'h12, 64'd0, 3'b010, 1, 1, 64'd0, 1);
    do_req(1'b1, 64'h800, 64'hDEAD, 3'b011, 1, 1, 64'd0, 1);
    do_req(1'b0, 64'h10, 64'd0, 3'b111, 1, 1, 64'd0, 1);
    do_req(1'b1, 64'h13, 64'h1234, 3'b100, 1, 1, 64'd0, 1);
    do_req(1'b0, 64'h10, 64'd0, 3'b011, 1, 1, 64'h88776655BEEFAB11, 0);
    wait_idle();

    // Backpressure: response held 5 cycles while a stray request is pulsed.
    rdy_mode = 2;
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_req(1'b0, 64'h14, 64'd0, 3'b010, 1, 1, 64'hFFFFFFFF88776655, 0);
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    rd0 = rsp_rdata;
    e0  = rsp_err;
    check("bp_first_rdata", rd0, 64'hFFFFFFFF88776655);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req_valid = (k == 1); req_we = 1'b1; req_addr = 64'h10; req_wdata = 64'd0; req_funct3 = 3'b011;
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rdata_stable", rsp_rdata, rd0);
      check("bp_err_stable", 64'(rsp_err), 64'(e0));
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_req_ready_after", 64'(req_ready), 64'd1);
    check("bp_rsp_valid_after", 64'(rsp_valid), 64'd0);
    rdy_mode = 0;
    do_req(1'b0, 64'h10, 64'd0, 3'b011, 1, 1, 64'h88776655BEEFAB11, 0);
    wait_idle();

    // Reset while a store is in BUSY: no response, no commit.
    do_req(1'b1, 64'h20, 64'h55, 3'b011, 1, 1, 64'd0, 0);
    do_req(1'b0, 64'h20, 64'd0, 3'b011, 1, 1, 64'h55, 0);
    wait_idle();
    do_req(1'b1, 64'h20, 64'h1, 3'b011, 0, 0, 64'd0, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_rsp_rdata", rsp_rdata, 64'd0);
    check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(1'b0, 64'h20, 64'd0, 3'b011, 1, 1, 64'h55, 0);
    wait_idle();

    // Random traffic against the byte model with random response backpressure.
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      f = w ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = 64'h800 + 64'($urandom_range(0, 4095));
      else begin
        a = 64'($urandom_range(0, DEPTH*8 - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 64'd1);
      end
      do_req(w, a, {$urandom, $urandom}, f, 1, 0, 64'd0, 0);
    end
    wait_idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected end before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
